// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. The fourth byte of a
// word is presented combinationally on word_out together with word_valid, so
// the consumer sees the complete word in the same cycle that byte transfers.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              strobe,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  // Only the first three bytes of a word need storage; the fourth is live.
  localparam int HELD_W = WORD_W - BYTE_W;

  logic [1:0]        cnt;
  logic [HELD_W-1:0] held;

  // Byte position counter and shift register; clear realigns to byte 0.
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      held <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (strobe) begin
      cnt  <= cnt + 2'd1;
      held <= {byte_in, held[HELD_W-1:BYTE_W]};
    end
  end

  assign word_out   = {byte_in, held};
  assign word_valid = strobe && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a 4-byte little-endian word-count header,
// then writes that many 32-bit words to consecutive instruction-memory
// addresses while holding the CPU stalled.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 32-bit checksum (sum of all data words mod 2^32) before DONE.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // One extra bit lets k reach DEPTH itself without wrapping.
  localparam int          KW        = $clog2(DEPTH) + 1;
  localparam logic [31:0] MAX_WORDS = 32'(DEPTH) - (BASE_ADDR >> 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t          state, next_state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   len;
  logic            strobe;
  logic            word_valid;
  logic [WORD_W-1:0] word;
  logic            load_begin;

  assign strobe     = in_valid && in_ready;
  assign load_begin = (next_state == LEN) && (state != LEN);

  // Byte counter restarts at every state entry.
  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (next_state != state),
    .strobe     (strobe),
    .byte_in    (in_data),
    .word_out   (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        last_word;

  assign last_word = ((k + KW'(1)) == len);

  // Running sum of data words, restarted with each load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (load_begin) begin
      sum <= '0;
    end else if (state == DATA && word_valid) begin
      sum <= sum + word;
    end
  end
`endif

  // Next-state decision.
  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) next_state = LEN;
      end
      LEN: begin
        if (word_valid) begin
          if (word == '0)            next_state = AFTER_DATA;
          else if (word > MAX_WORDS) next_state = ERR;
          else                       next_state = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum bytes may follow the last data byte back-to-back, so CSUM is
      // entered on the last byte while its write is still being strobed.
      DATA: begin
        if (word_valid && last_word) next_state = CSUM;
      end
      CSUM: begin
        if (word_valid) next_state = (word == sum) ? DONE : ERR;
      end
`else
      // Leave DATA only after the final write strobe so the last word has
      // committed before done releases the core.
      DATA: begin
        if (wr_en && (k == len)) next_state = DONE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // State register, write port and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= '0;
      len      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= next_state inside {LEN, DATA, CSUM};
      cpu_hold <= (next_state != DONE);
      done     <= (next_state == DONE);
      error    <= (next_state == ERR);
      wr_en    <= 1'b0;

      if (load_begin) k <= '0;

      // Length has passed the range check whenever DATA is entered, so the
      // truncated copy is exact.
      if (state == LEN && word_valid) len <= word[KW-1:0];

      if (state == DATA && word_valid) begin
        wr_en   <= 1'b1;
        wr_addr <= BASE_ADDR + (32'(k) << 2);
        wr_data <= word;
        k       <= k + KW'(1);
      end
    end
  end

endmodule
